// File: rtl/conv3x3_filter.sv
// 3x3 neighbourhood filter for the greyscale video path: bypass, Sobel edge, Gaussian blur or sharpen.
// Two-stage pipeline (window update, then arithmetic/clamp); the filter mode is latched once per frame.
module conv3x3_filter #(
   parameter int PIX_W = 4,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode_sel,
   input  logic [PIX_W-1:0] pixel_in,
   input  logic             in_ready,
   output logic [PIX_W-1:0] pixel_out,
   output logic             out_ready,
   output logic             frame_done,
   output logic [1:0]       active_mode
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int AW = PIX_W + 4;
   localparam logic signed [AW-1:0] MAX_S = AW'((1 << PIX_W) - 1);

   logic [XW-1:0]    x;
   logic [YW-1:0]    y;
   logic             frame_start;
   logic             x_last;
   logic             y_last;
   logic [1:0]       pix_mode;

   logic             s1_vld;
   logic             s1_border;
   logic             s1_last;
   logic [1:0]       s1_mode;

   logic [PIX_W-1:0] lb1 [IMG_W];
   logic [PIX_W-1:0] lb2 [IMG_W];
   logic [PIX_W-1:0] win [3][3];

   logic signed [AW-1:0] p_c, p_n, p_s, p_e, p_w, p_nw, p_ne, p_sw, p_se;
   logic signed [AW-1:0] gx, gy, ax, ay, sob, shp, res;
   logic [AW-1:0]        gsum;
   logic [PIX_W-1:0]     clamped;

   assign frame_start = (x == '0) && (y == '0);
   assign x_last      = (x == XW'(IMG_W - 1));
   assign y_last      = (y == YW'(IMG_H - 1));
   // The pixel that opens a frame already runs in the newly requested mode.
   assign pix_mode    = frame_start ? mode_sel : active_mode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x           <= '0;
         y           <= '0;
         active_mode <= '0;
         s1_vld      <= 1'b0;
         s1_border   <= 1'b0;
         s1_last     <= 1'b0;
         s1_mode     <= '0;
      end else begin
         s1_vld <= in_ready;
         if (in_ready) begin
            s1_border <= (x < XW'(2)) || (y < YW'(2));
            s1_last   <= x_last && y_last;
            s1_mode   <= pix_mode;
            if (frame_start)
               active_mode <= mode_sel;
            if (x_last) begin
               x <= '0;
               y <= y_last ? '0 : y + YW'(1);
            end else begin
               x <= x + XW'(1);
            end
         end
      end
   end

   // Line buffers and window carry no reset: stale contents are masked by the border rule.
   always_ff @(posedge clk) begin
      if (in_ready) begin
         lb1[x] <= pixel_in;
         lb2[x] <= lb1[x];
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= lb2[x];
         win[1][2] <= lb1[x];
         win[2][2] <= pixel_in;
      end
   end

   assign p_nw = signed'({4'b0000, win[0][0]});
   assign p_n  = signed'({4'b0000, win[0][1]});
   assign p_ne = signed'({4'b0000, win[0][2]});
   assign p_w  = signed'({4'b0000, win[1][0]});
   assign p_c  = signed'({4'b0000, win[1][1]});
   assign p_e  = signed'({4'b0000, win[1][2]});
   assign p_sw = signed'({4'b0000, win[2][0]});
   assign p_s  = signed'({4'b0000, win[2][1]});
   assign p_se = signed'({4'b0000, win[2][2]});

   always_comb begin
      gx  = (p_ne + (p_e <<< 1) + p_se) - (p_nw + (p_w <<< 1) + p_sw);
      gy  = (p_sw + (p_s <<< 1) + p_se) - (p_nw + (p_n <<< 1) + p_ne);
      ax  = gx[AW-1] ? -gx : gx;
      ay  = gy[AW-1] ? -gy : gy;
      sob = ax + ay;
      // Blur sum reaches 16*MAX, which only fits AW bits as unsigned; shift logically.
      gsum = (p_c <<< 2) + ((p_n + p_s + p_e + p_w) <<< 1) + (p_nw + p_ne + p_sw + p_se);
      shp  = (p_c <<< 2) + p_c - p_n - p_s - p_e - p_w;
      case (s1_mode)
         2'd0:    res = p_c;
         2'd1:    res = sob;
         2'd2:    res = signed'(gsum >> 4);
         default: res = shp;
      endcase
      if (res < 0)
         clamped = '0;
      else if (res > MAX_S)
         clamped = '1;
      else
         clamped = res[PIX_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixel_out  <= '0;
         out_ready  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         out_ready  <= s1_vld;
         frame_done <= s1_vld && s1_last;
         if (s1_vld)
            pixel_out <= s1_border ? '0 : clamped;
      end
   end

endmodule

// File: tb/tb_conv3x3_filter.sv
// Directed bench for conv3x3_filter on an 8x4 frame with 4-bit pixels.
// Expected pixels come from hand-picked constants and an image-domain reference model.
module tb_conv3x3_filter;

   localparam int PW = 4;
   localparam int W  = 8;
   localparam int H  = 4;
   localparam int N  = W * H;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    mode_sel;
   logic [PW-1:0] pixel_in;
   logic          in_ready;
   logic [PW-1:0] pixel_out;
   logic          out_ready;
   logic          frame_done;
   logic [1:0]    active_mode;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int img [N];
   int drv_q [$];
   int out_pix_q [$];
   int out_fd_q [$];
   int ramp_ref [$];

   always #5 clk = ~clk;

   conv3x3_filter #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
      .clk         (clk),
      .rst         (rst),
      .mode_sel    (mode_sel),
      .pixel_in    (pixel_in),
      .in_ready    (in_ready),
      .pixel_out   (pixel_out),
      .out_ready   (out_ready),
      .frame_done  (frame_done),
      .active_mode (active_mode)
   );

   task automatic check_val(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Output collector: also checks the 2-cycle latency against the drive cycle.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (out_ready === 1'b1) begin
         if (drv_q.size() == 0)
            check_val("spurious_out_ready", 1, 0);
         else
            check_val("latency", cyc - drv_q.pop_front(), 2);
         out_pix_q.push_back(int'(pixel_out));
         out_fd_q.push_back(int'(frame_done));
      end else if (frame_done !== 1'b0) begin
         check_val("frame_done_without_out_ready", 1, 0);
      end
   end

   function automatic int px(int x, int y);
      return img[y * W + x];
   endfunction

   function automatic int model(int m, int x, int y);
      int c, n, s, e, w, nw, ne, sw, se, gx, gy, r;
      if (x < 2 || y < 2) return 0;
      c  = px(x - 1, y - 1);
      n  = px(x - 1, y - 2);
      s  = px(x - 1, y);
      w  = px(x - 2, y - 1);
      e  = px(x, y - 1);
      nw = px(x - 2, y - 2);
      ne = px(x, y - 2);
      sw = px(x - 2, y);
      se = px(x, y);
      case (m)
         0: r = c;
         1: begin
            gx = (ne + 2 * e + se) - (nw + 2 * w + sw);
            gy = (sw + 2 * s + se) - (nw + 2 * n + ne);
            r  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
         end
         2: r = (4 * c + 2 * (n + s + e + w) + nw + ne + sw + se) / 16;
         default: r = 5 * c - n - s - e - w;
      endcase
      if (r < 0) r = 0;
      if (r > 15) r = 15;
      return r;
   endfunction

   task automatic send(input int p);
      @(negedge clk);
      pixel_in = PW'(p);
      in_ready = 1'b1;
      drv_q.push_back(cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_ready = 1'b0;
      end
   endtask

   task automatic run_frame();
      for (int k = 0; k < N; k++) send(img[k]);
      idle(4);
   endtask

   task automatic check_frame(input string tag, input int m, input int nfr);
      int fd_cnt;
      fd_cnt = 0;
      check_val({tag, "_out_count"}, out_pix_q.size(), N * nfr);
      for (int i = 0; i < out_pix_q.size() && i < N * nfr; i++) begin
         int k;
         k = i % N;
         check_val($sformatf("%s_pix%0d", tag, i), out_pix_q[i], model(m, k % W, k / W));
         check_val($sformatf("%s_fd%0d", tag, i), out_fd_q[i], (k == N - 1) ? 1 : 0);
         fd_cnt += out_fd_q[i];
      end
      check_val({tag, "_fd_count"}, fd_cnt, nfr);
      check_val({tag, "_drained"}, drv_q.size(), 0);
      out_pix_q.delete();
      out_fd_q.delete();
   endtask

   task automatic set_ramp();
      for (int k = 0; k < N; k++) img[k] = k % 16;
   endtask

   task automatic set_edge();
      for (int k = 0; k < N; k++) img[k] = ((k % W) < 4) ? 0 : 15;
   endtask

   task automatic set_const(input int v);
      for (int k = 0; k < N; k++) img[k] = v;
   endtask

   initial begin
      rst      = 1'b1;
      mode_sel = 2'd0;
      pixel_in = '0;
      in_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_pixel_out", int'(pixel_out), 0);
      check_val("rst_out_ready", int'(out_ready), 0);
      check_val("rst_frame_done", int'(frame_done), 0);
      check_val("rst_active_mode", int'(active_mode), 0);
      rst = 1'b0;
      idle(2);

      set_ramp();
      mode_sel = 2'd0;
      run_frame();
      ramp_ref = out_pix_q;
      if (out_pix_q.size() == N) begin
         check_val("bypass_out_3_2", out_pix_q[19], 10);
         check_val("bypass_out_1_3", out_pix_q[25], 0);
         check_val("bypass_out_7_3", out_pix_q[31], 6);
      end
      check_frame("bypass", 0, 1);

      set_edge();
      mode_sel = 2'd1;
      run_frame();
      check_val("sobel_active_mode", int'(active_mode), 1);
      if (out_pix_q.size() == N) begin
         check_val("sobel_edge_4_2", out_pix_q[20], 15);
         check_val("sobel_edge_5_2", out_pix_q[21], 15);
         check_val("sobel_edge_4_3", out_pix_q[28], 15);
         check_val("sobel_edge_5_3", out_pix_q[29], 15);
         check_val("sobel_flat_6_2", out_pix_q[22], 0);
         check_val("sobel_flat_3_2", out_pix_q[19], 0);
         check_val("sobel_border_4_1", out_pix_q[12], 0);
      end
      check_frame("sobel", 1, 1);

      set_const(9);
      mode_sel = 2'd2;
      run_frame();
      if (out_pix_q.size() == N) check_val("gauss_const_3_3", out_pix_q[27], 9);
      check_frame("gauss", 2, 1);

      mode_sel = 2'd3;
      run_frame();
      if (out_pix_q.size() == N) check_val("sharp_const_3_3", out_pix_q[27], 9);
      check_frame("sharp", 3, 1);

      set_const(0);
      img[2 * W + 3] = 15;
      run_frame();
      if (out_pix_q.size() == N) begin
         check_val("sharp_peak_centre", out_pix_q[28], 15);
         check_val("sharp_peak_north", out_pix_q[20], 0);
         check_val("sharp_peak_west", out_pix_q[27], 0);
         check_val("sharp_peak_east", out_pix_q[29], 0);
      end
      check_frame("sharp_peak", 3, 1);

      set_edge();
      mode_sel = 2'd0;
      for (int k = 0; k < N; k++) begin
         send(img[k]);
         if (k == 10) mode_sel = 2'd1;
      end
      idle(4);
      check_val("latch_hold_mode", int'(active_mode), 0);
      if (out_pix_q.size() == N) check_val("latch_bypass_4_2", out_pix_q[20], 0);
      check_frame("latch_frame", 0, 1);
      send(img[0]);
      idle(1);
      check_val("latch_new_mode", int'(active_mode), 1);
      for (int k = 1; k < N; k++) send(img[k]);
      idle(4);
      check_frame("latch_next", 1, 1);

      set_ramp();
      mode_sel = 2'd0;
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < N; k++) begin
            send(img[k]);
            idle(int'($urandom_range(5, 0)));
         end
      end
      idle(4);
      if (out_pix_q.size() == 2 * N && ramp_ref.size() == N) begin
         for (int i = 0; i < 2 * N; i++)
            check_val($sformatf("gap_vs_b2b%0d", i), out_pix_q[i], ramp_ref[i % N]);
      end
      check_frame("gapped", 0, 2);

      mode_sel = 2'd3;
      for (int k = 0; k < 13; k++) send(img[k]);
      @(posedge clk);
      #1;
      check_val("pre_rst_out_ready", int'(out_ready), 1);
      #1;
      rst      = 1'b1;
      in_ready = 1'b0;
      #1;
      check_val("async_rst_pixel_out", int'(pixel_out), 0);
      check_val("async_rst_out_ready", int'(out_ready), 0);
      check_val("async_rst_frame_done", int'(frame_done), 0);
      check_val("async_rst_active_mode", int'(active_mode), 0);
      check_val("pre_rst_out_count", out_pix_q.size(), 12);
      drv_q.delete();
      out_pix_q.delete();
      out_fd_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(3);
      check_val("no_inflight_outs", out_pix_q.size(), 0);
      run_frame();
      check_frame("post_rst", 3, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
